core_seq: RTL and testbench

Multi-cycle sequencer for the RV64 core datapath (idu/exu/RegisterFile/pc). It issues instruction fetches over a valid/ready request channel and latches the returned instruction for the decoder. It then steps a fixed FETCH→WAIT→EXEC→WB sequence that gates the GPR and PC write enables. It stops the core on ebreak, fetch error or fetch timeout, and reports the cause plus a retired-instruction count to the simulation harness.

---
 rtl/core_seq.sv | 139 +++++++++++++
 tb/tb_core_seq.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq.sv
// ---------------------------------------------------------------------------
// core_seq
//
// Multi-cycle sequencer for the RV64 core datapath. Each instruction walks
// FETCH -> WAIT -> EXEC -> WB. The block issues a fetch request for the
// current pc and latches the returned instruction for idu/exu. It pulses the
// GPR and PC write enables in WB. It stops the core on ebreak, on a fetch
// error or on a fetch timeout.
//
// Ports:
//   clk            core clock, all state on the rising edge
//   rst            asynchronous, active-high reset
//   ifu_req_valid  fetch request for the current pc (FETCH only)
//   ifu_req_ready  memory accepts the request
//   ifu_rsp_valid  fetch response present (only looked at in WAIT)
//   ifu_rsp_inst   fetched instruction
//   ifu_rsp_err    fetch fault, qualified by ifu_rsp_valid
//   exu_wen        exu says the current instruction writes rd
//   inst           latched instruction driven to idu/exu
//   gpr_wen        RegisterFile write enable, single-cycle pulse in WB
//   pc_wen         pc advance enable, single-cycle pulse in WB
//   halted         core stopped
//   halt_code      0 none, 1 ebreak, 2 fetch error, 3 fetch timeout
//   retired        instructions retired since reset, saturating
// ---------------------------------------------------------------------------
module core_seq #(
    parameter int FETCH_TIMEOUT = 255,
    parameter int TO_W          = 8,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    input  logic             ifu_rsp_valid,
    input  logic [31:0]      ifu_rsp_inst,
    input  logic             ifu_rsp_err,
    input  logic             exu_wen,
    output logic [31:0]      inst,
    output logic             gpr_wen,
    output logic             pc_wen,
    output logic             halted,
    output logic [1:0]       halt_code,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [1:0] CODE_NONE    = 2'd0;
    localparam logic [1:0] CODE_EBREAK  = 2'd1;
    localparam logic [1:0] CODE_FETCH   = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    // The counter reads 0 in the first WAIT cycle, so reaching this value
    // means FETCH_TIMEOUT WAIT cycles have elapsed without a response.
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(FETCH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]      state;
    logic [TO_W-1:0] to_cnt;

    // Sequencer state, instruction latch, halt cause and retire counter.
    // A response is only accepted in WAIT. This keeps at most one request
    // outstanding and drops any stale response that arrives in FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            inst      <= INST_NOP;
            halt_code <= CODE_NONE;
            retired   <= '0;
            to_cnt    <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (ifu_req_ready) begin
                        state  <= S_WAIT;
                        to_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    // A response beats a timeout that lands in the same cycle.
                    if (ifu_rsp_valid) begin
                        if (ifu_rsp_err) begin
                            state     <= S_HALT;
                            halt_code <= CODE_FETCH;
                        end else begin
                            inst  <= ifu_rsp_inst;
                            state <= S_EXEC;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state     <= S_HALT;
                        halt_code <= CODE_TIMEOUT;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_EXEC: begin
                    // ebreak counts as retired but never writes GPR or PC.
                    if (inst == INST_EBREAK) begin
                        state     <= S_HALT;
                        halt_code <= CODE_EBREAK;
                        if (retired != CNT_MAX) begin
                            retired <= retired + CNT_W'(1);
                        end
                    end else begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                    if (retired != CNT_MAX) begin
                        retired <= retired + CNT_W'(1);
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Outputs decode straight from state. Because reset forces state to
    // FETCH asynchronously, the write enables drop as soon as rst rises.
    assign ifu_req_valid = (state == S_FETCH);
    assign pc_wen        = (state == S_WB);
    assign gpr_wen       = (state == S_WB) && exu_wen;
    assign halted        = (state == S_HALT);

endmodule

// File: tb/tb_core_seq.sv
// ---------------------------------------------------------------------------
// tb_core_seq
//
// Directed self-checking bench for core_seq. The DUT is built with
// FETCH_TIMEOUT=4 so the timeout path is short. Inputs are driven 1ns after
// each rising edge. Outputs are sampled in the same window, well away from
// the next edge.
// ---------------------------------------------------------------------------
module tb_core_seq;

    localparam int TO      = 4;
    localparam int CNT_W   = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ADDI   = 32'h0010_0093;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic             clk;
    logic             rst;
    logic             ifu_req_valid;
    logic             ifu_req_ready;
    logic             ifu_rsp_valid;
    logic [31:0]      ifu_rsp_inst;
    logic             ifu_rsp_err;
    logic             exu_wen;
    logic [31:0]      inst;
    logic             gpr_wen;
    logic             pc_wen;
    logic             halted;
    logic [1:0]       halt_code;
    logic [CNT_W-1:0] retired;

    int pass_cnt  = 0;
    int total_cnt = 0;

    core_seq #(
        .FETCH_TIMEOUT(TO),
        .TO_W(8),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_inst(ifu_rsp_inst),
        .ifu_rsp_err(ifu_rsp_err),
        .exu_wen(exu_wen),
        .inst(inst),
        .gpr_wen(gpr_wen),
        .pc_wen(pc_wen),
        .halted(halted),
        .halt_code(halt_code),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset pulse. On return the DUT is in its first FETCH cycle.
    task automatic do_reset;
        rst           = 1'b1;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = 32'h0;
        ifu_rsp_err   = 1'b0;
        exu_wen       = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        ifu_req_ready = 1'b1;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = EBREAK;
        ifu_rsp_err   = 1'b0;
        exu_wen       = 1'b1;
        tick();
        tick();
        total_cnt++;
        if ({halted, halt_code} !== 3'b000) $display("[TB] FAIL reset_halt: got %b expected 000", {halted, halt_code});
        else pass_cnt++;
        total_cnt++;
        if (retired !== '0) $display("[TB] FAIL reset_retired: got %0d expected 0", retired);
        else pass_cnt++;
        total_cnt++;
        if (inst !== NOP) $display("[TB] FAIL reset_inst: got %h expected %h", inst, NOP);
        else pass_cnt++;
        total_cnt++;
        if ({gpr_wen, pc_wen} !== 2'b00) $display("[TB] FAIL reset_wen: got %b expected 00", {gpr_wen, pc_wen});
        else pass_cnt++;
        total_cnt++;
        if (ifu_req_valid !== 1'b1) $display("[TB] FAIL reset_req_valid: got %b expected 1", ifu_req_valid);
        else pass_cnt++;
    endtask

    // Zero-wait memory: three addi instructions at 4 cycles each.
    task automatic test_basic;
        do_reset();
        ifu_req_ready = 1'b1;
        exu_wen       = 1'b1;
        for (int n = 0; n < 3; n++) begin
            total_cnt++;
            if ({ifu_req_valid, pc_wen} !== 2'b10) $display("[TB] FAIL basic_fetch%0d: got %b expected 10", n, {ifu_req_valid, pc_wen});
            else pass_cnt++;
            tick();
            ifu_rsp_valid = 1'b1;
            ifu_rsp_inst  = ADDI;
            total_cnt++;
            if (ifu_req_valid !== 1'b0) $display("[TB] FAIL basic_wait%0d: got %b expected 0", n, ifu_req_valid);
            else pass_cnt++;
            tick();
            ifu_rsp_valid = 1'b0;
            total_cnt++;
            if ({inst, gpr_wen, pc_wen} !== {ADDI, 2'b00}) $display("[TB] FAIL basic_exec%0d: got %h/%b expected %h/00", n, inst, {gpr_wen, pc_wen}, ADDI);
            else pass_cnt++;
            tick();
            total_cnt++;
            if ({gpr_wen, pc_wen} !== 2'b11 || retired !== CNT_W'(n)) $display("[TB] FAIL basic_wb%0d: got %b ret %0d expected 11 ret %0d", n, {gpr_wen, pc_wen}, retired, n);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (retired !== 32'd3 || ifu_req_valid !== 1'b1) $display("[TB] FAIL basic_retired: got %0d valid %b expected 3 valid 1", retired, ifu_req_valid);
        else pass_cnt++;
    endtask

    task automatic test_ready_stall;
        do_reset();
        ifu_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({ifu_req_valid, pc_wen} !== 2'b10) $display("[TB] FAIL stall_cycle%0d: got %b expected 10", i, {ifu_req_valid, pc_wen});
            else pass_cnt++;
            tick();
        end
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        total_cnt++;
        if (ifu_req_valid !== 1'b0) $display("[TB] FAIL stall_enter_wait: got %b expected 0", ifu_req_valid);
        else pass_cnt++;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = NOP;
        tick();
        ifu_rsp_valid = 1'b0;
        tick();
        total_cnt++;
        if ({gpr_wen, pc_wen} !== 2'b01) $display("[TB] FAIL stall_wb: got %b expected 01", {gpr_wen, pc_wen});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (retired !== 32'd1) $display("[TB] FAIL stall_retired: got %0d expected 1", retired);
        else pass_cnt++;
    endtask

    task automatic test_ebreak;
        do_reset();
        ifu_req_ready = 1'b1;
        exu_wen       = 1'b1;
        tick();
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = EBREAK;
        tick();
        ifu_rsp_valid = 1'b0;
        total_cnt++;
        if ({inst, gpr_wen, pc_wen} !== {EBREAK, 2'b00}) $display("[TB] FAIL ebreak_exec: got %h/%b expected %h/00", inst, {gpr_wen, pc_wen}, EBREAK);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({halted, halt_code} !== 3'b101 || retired !== 32'd1) $display("[TB] FAIL ebreak_halt: got %b ret %0d expected 101 ret 1", {halted, halt_code}, retired);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            ifu_rsp_valid = i[0];
            ifu_rsp_inst  = ADDI;
            ifu_rsp_err   = i[1];
            tick();
            total_cnt++;
            if ({halted, halt_code, gpr_wen, pc_wen, ifu_req_valid} !== 6'b101000 || inst !== EBREAK || retired !== 32'd1)
                $display("[TB] FAIL ebreak_absorb%0d: got %b inst %h ret %0d expected 101000 inst %h ret 1", i, {halted, halt_code, gpr_wen, pc_wen, ifu_req_valid}, inst, retired, EBREAK);
            else pass_cnt++;
        end
        ifu_rsp_valid = 1'b0;
        ifu_rsp_err   = 1'b0;
    endtask

    task automatic test_fetch_err;
        do_reset();
        ifu_req_ready = 1'b1;
        tick();
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = ADDI;
        tick();
        ifu_rsp_valid = 1'b0;
        tick();
        tick();
        tick();
        ifu_rsp_valid = 1'b1;
        ifu_rsp_err   = 1'b1;
        ifu_rsp_inst  = 32'hDEAD_BEEF;
        tick();
        ifu_rsp_valid = 1'b0;
        ifu_rsp_err   = 1'b0;
        total_cnt++;
        if ({halted, halt_code} !== 3'b110 || inst !== ADDI || retired !== 32'd1)
            $display("[TB] FAIL fetch_err: got %b inst %h ret %0d expected 110 inst %h ret 1", {halted, halt_code}, inst, retired, ADDI);
        else pass_cnt++;
    endtask

    task automatic test_timeout;
        do_reset();
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            total_cnt++;
            if ({halted, ifu_req_valid} !== 2'b00) $display("[TB] FAIL timeout_wait%0d: got %b expected 00", i, {halted, ifu_req_valid});
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({halted, halt_code} !== 3'b111) $display("[TB] FAIL timeout_halt: got %b expected 111", {halted, halt_code});
        else pass_cnt++;

        // Response on the last allowed WAIT cycle beats the timeout.
        do_reset();
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        tick();
        tick();
        tick();
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = ADDI;
        tick();
        ifu_rsp_valid = 1'b0;
        total_cnt++;
        if (halted !== 1'b0 || inst !== ADDI) $display("[TB] FAIL timeout_race: got halted %b inst %h expected 0 %h", halted, inst, ADDI);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (pc_wen !== 1'b1) $display("[TB] FAIL timeout_race_wb: got %b expected 1", pc_wen);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        // Retire one instruction, then reset in the middle of the next WB.
        do_reset();
        ifu_req_ready = 1'b1;
        exu_wen       = 1'b1;
        for (int n = 0; n < 2; n++) begin
            tick();
            ifu_rsp_valid = 1'b1;
            ifu_rsp_inst  = ADDI;
            tick();
            ifu_rsp_valid = 1'b0;
            tick();
            if (n == 0) tick();
        end
        total_cnt++;
        if ({gpr_wen, pc_wen} !== 2'b11 || retired !== 32'd1) $display("[TB] FAIL midwb_pre: got %b ret %0d expected 11 ret 1", {gpr_wen, pc_wen}, retired);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({gpr_wen, pc_wen} !== 2'b00 || retired !== '0 || inst !== NOP)
            $display("[TB] FAIL midwb_reset: got %b ret %0d inst %h expected 00 ret 0 inst %h", {gpr_wen, pc_wen}, retired, inst, NOP);
        else pass_cnt++;
        tick();
        rst = 1'b0;

        // Reset in the middle of WAIT.
        tick();
        total_cnt++;
        if (ifu_req_valid !== 1'b0) $display("[TB] FAIL midwait_pre: got %b expected 0", ifu_req_valid);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({ifu_req_valid, gpr_wen, pc_wen, halted} !== 4'b1000 || inst !== NOP)
            $display("[TB] FAIL midwait_reset: got %b inst %h expected 1000 inst %h", {ifu_req_valid, gpr_wen, pc_wen, halted}, inst, NOP);
        else pass_cnt++;
        tick();
        rst = 1'b0;

        // Stale response in the first FETCH cycle must be dropped.
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = EBREAK;
        tick();
        ifu_rsp_valid = 1'b0;
        total_cnt++;
        if (ifu_req_valid !== 1'b1 || inst !== NOP) $display("[TB] FAIL stale_rsp: got valid %b inst %h expected 1 %h", ifu_req_valid, inst, NOP);
        else pass_cnt++;
        ifu_req_ready = 1'b1;
        tick();
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = ADDI;
        tick();
        ifu_rsp_valid = 1'b0;
        total_cnt++;
        if (inst !== ADDI) $display("[TB] FAIL restart_inst: got %h expected %h", inst, ADDI);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (retired !== 32'd1 || halted !== 1'b0) $display("[TB] FAIL restart_retired: got %0d halted %b expected 1 0", retired, halted);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_stall();
        test_ebreak();
        test_fetch_err();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
